// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   fwd_t / FWD_*   : operand-forwarding select codes driven to the Execute muxes
//   RESULT_LOAD     : ResultSrcE value that identifies a load in Execute
//   mem_state_t     : data-memory wait FSM states
//   fwd_sel()       : priority encoder turning stage-hit flags into a select code
package hazard_pkg;

   typedef logic [1:0] fwd_t;

   localparam fwd_t FWD_REG = 2'b00;
   localparam fwd_t FWD_WB  = 2'b01;
   localparam fwd_t FWD_MEM = 2'b10;

   localparam logic [1:0] RESULT_LOAD = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // Memory stage holds the younger result, so it wins over Writeback.
   function automatic fwd_t fwd_sel(input logic mem_hit, input logic wb_hit);
      if (mem_hit) begin
         return FWD_MEM;
      end else if (wb_hit) begin
         return FWD_WB;
      end
      return FWD_REG;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of every pipeline-facing signal of the hazard controller.
//   master : pipeline side, drives register indices and control, reads hazard decisions
//   slave  : hazard controller side
// Widths follow REGISTER_ADDRESS_WIDTH (register indices) and COUNTER_WIDTH
// (performance counters); they must match the controller instance parameters.
interface hazard_ctrl_if
   import hazard_pkg::*;
#(
   parameter int REGISTER_ADDRESS_WIDTH = 5,
   parameter int COUNTER_WIDTH          = 32
);
   logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i;
   logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i, RdM_i, RdW_i;
   logic [1:0]                        ResultSrcE_i;
   logic                              RegWriteM_i, RegWriteW_i;
   logic                              PCSrcE_i, MemAccessM_i, DMemReady_i, ClrCnt_i;

   fwd_t                              ForwardAE_o, ForwardBE_o;
   logic                              StallF_o, StallD_o, StallE_o, StallM_o;
   logic                              FlushD_o, FlushE_o, BubbleW_o;
   logic                              ValidE_o, ValidM_o, ValidW_o;
   logic                              MemTimeout_o;
   logic [COUNTER_WIDTH-1:0]          StallCnt_o, FlushCnt_o;

   modport master (
      output Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
             ResultSrcE_i, RegWriteM_i, RegWriteW_i,
             PCSrcE_i, MemAccessM_i, DMemReady_i, ClrCnt_i,
      input  ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
             FlushD_o, FlushE_o, BubbleW_o, ValidE_o, ValidM_o, ValidW_o,
             MemTimeout_o, StallCnt_o, FlushCnt_o
   );

   modport slave (
      input  Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i,
             ResultSrcE_i, RegWriteM_i, RegWriteW_i,
             PCSrcE_i, MemAccessM_i, DMemReady_i, ClrCnt_i,
      output ForwardAE_o, ForwardBE_o, StallF_o, StallD_o, StallE_o, StallM_o,
             FlushD_o, FlushE_o, BubbleW_o, ValidE_o, ValidM_o, ValidW_o,
             MemTimeout_o, StallCnt_o, FlushCnt_o
   );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   inc          : count one event this cycle
//   clr          : synchronous clear, wins over inc
//   count        : current value, sticks at all-ones
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   assign count = count_reg;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// flush, data-memory wait stall with timeout, stage-valid tracking and
// stall/flush performance counters.
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   hz    : hazard_ctrl_if slave port (all pipeline inputs and hazard outputs)
// Forwarding, stall and flush outputs are combinational from their inputs.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REGISTER_ADDRESS_WIDTH = 5,
   parameter int COUNTER_WIDTH          = 32,
   parameter int MEM_TIMEOUT            = 255
) (
   input  logic         clk_i,
   input  logic         rst_i,
   hazard_ctrl_if.slave hz
);
   localparam logic [REGISTER_ADDRESS_WIDTH-1:0] REG_ZERO = '0;
   // Wait counter is at least 9 bits and always wide enough for MEM_TIMEOUT.
   localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 9) ? $clog2(MEM_TIMEOUT + 1) : 9;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   logic              valid_d_reg, valid_e_reg, valid_m_reg, valid_w_reg;
   mem_state_t        state_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              timeout_reg;

   logic lw_stall, mem_stall;
   logic stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, bubble_w;

   // ---------------- forwarding, one lane per Execute source operand
   logic [REGISTER_ADDRESS_WIDTH-1:0] rs_e [2];
   fwd_t                              fwd  [2];

   assign rs_e[0] = hz.Rs1E_i;
   assign rs_e[1] = hz.Rs2E_i;

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit, wb_hit;
      assign mem_hit = hz.RegWriteM_i && valid_m_reg && (hz.RdM_i != REG_ZERO) && (hz.RdM_i == rs_e[gi]);
      assign wb_hit  = hz.RegWriteW_i && valid_w_reg && (hz.RdW_i != REG_ZERO) && (hz.RdW_i == rs_e[gi]);
      assign fwd[gi] = fwd_sel(mem_hit, wb_hit);
   end

   assign hz.ForwardAE_o = fwd[0];
   assign hz.ForwardBE_o = fwd[1];

   // ---------------- stall / flush decisions
   assign lw_stall  = (hz.ResultSrcE_i == RESULT_LOAD) && valid_e_reg && (hz.RdE_i != REG_ZERO) &&
                      ((hz.RdE_i == hz.Rs1D_i) || (hz.RdE_i == hz.Rs2D_i));
   // Once the timeout flag is set the pipeline is never held for memory again.
   assign mem_stall = valid_m_reg && hz.MemAccessM_i && !hz.DMemReady_i && !timeout_reg;

   // A memory wait freezes the whole pipe and defers any branch or load-use
   // action; otherwise a taken branch flushes and masks the load-use stall.
   assign stall_f  = mem_stall | (lw_stall & ~hz.PCSrcE_i);
   assign stall_d  = stall_f;
   assign stall_e  = mem_stall;
   assign stall_m  = mem_stall;
   assign bubble_w = mem_stall;
   assign flush_d  = ~mem_stall & hz.PCSrcE_i;
   assign flush_e  = ~mem_stall & (hz.PCSrcE_i | lw_stall);

   assign hz.StallF_o  = stall_f;
   assign hz.StallD_o  = stall_d;
   assign hz.StallE_o  = stall_e;
   assign hz.StallM_o  = stall_m;
   assign hz.BubbleW_o = bubble_w;
   assign hz.FlushD_o  = flush_d;
   assign hz.FlushE_o  = flush_e;

   // ---------------- stage-valid bits
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         valid_d_reg <= 1'b0;
         valid_e_reg <= 1'b0;
         valid_m_reg <= 1'b0;
         valid_w_reg <= 1'b0;
      end else begin
         if (flush_d)       valid_d_reg <= 1'b0;
         else if (!stall_d) valid_d_reg <= 1'b1;

         if (flush_e)       valid_e_reg <= 1'b0;
         else if (!stall_e) valid_e_reg <= valid_d_reg;

         if (!stall_m)      valid_m_reg <= valid_e_reg;

         valid_w_reg <= bubble_w ? 1'b0 : valid_m_reg;
      end
   end

   assign hz.ValidE_o = valid_e_reg;
   assign hz.ValidM_o = valid_m_reg;
   assign hz.ValidW_o = valid_w_reg;

   // ---------------- data-memory wait FSM with timeout
   // The wait counter holds the number of stalled cycles already spent; the
   // cycle on which it would reach MEM_TIMEOUT records the timeout instead.
   // WAIT is left whenever the stall condition drops (ready, stage emptied,
   // or the access itself withdrawn) so an abandoned access never times out.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (mem_stall) begin
                  if (wait_cnt_reg == WAIT_LAST) begin
                     timeout_reg <= 1'b1;
                  end else begin
                     state_reg    <= WAIT;
                     wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
                  end
               end
            end
            WAIT: begin
               if (!mem_stall) begin
                  state_reg    <= IDLE;
                  wait_cnt_reg <= '0;
               end else if (wait_cnt_reg == WAIT_LAST) begin
                  timeout_reg  <= 1'b1;
                  state_reg    <= IDLE;
                  wait_cnt_reg <= '0;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + WAIT_ONE;
               end
            end
            default: begin
               state_reg    <= IDLE;
               wait_cnt_reg <= '0;
            end
         endcase
      end
   end

   assign hz.MemTimeout_o = timeout_reg;

   // ---------------- performance counters
   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (stall_f),
      .clr   (hz.ClrCnt_i),
      .count (hz.StallCnt_o)
   );

   sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (flush_d),
      .clr   (hz.ClrCnt_i),
      .count (hz.FlushCnt_o)
   );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (COUNTER_WIDTH=4, MEM_TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
module tb_hazard_ctrl;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.REGISTER_ADDRESS_WIDTH(5), .COUNTER_WIDTH(4)) bus ();

   hazard_ctrl #(
      .REGISTER_ADDRESS_WIDTH (5),
      .COUNTER_WIDTH          (4),
      .MEM_TIMEOUT            (4)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .hz    (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      bus.Rs1D_i = '0; bus.Rs2D_i = '0; bus.Rs1E_i = '0; bus.Rs2E_i = '0;
      bus.RdE_i = '0; bus.RdM_i = '0; bus.RdW_i = '0;
      bus.ResultSrcE_i = 2'b00; bus.RegWriteM_i = 1'b0; bus.RegWriteW_i = 1'b0;
      bus.PCSrcE_i = 1'b0; bus.MemAccessM_i = 1'b0; bus.DMemReady_i = 1'b0; bus.ClrCnt_i = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      set_idle();
      #1 rst = 1'b0;
      #1;
      // ---- reset state
      chk("rst_valid_e", bus.ValidE_o, 0);
      chk("rst_valid_m", bus.ValidM_o, 0);
      chk("rst_valid_w", bus.ValidW_o, 0);
      chk("rst_timeout", bus.MemTimeout_o, 0);
      chk("rst_stall_cnt", bus.StallCnt_o, 0);
      chk("rst_flush_cnt", bus.FlushCnt_o, 0);
      // ---- nothing valid: no forwarding or stalls whatever the inputs
      bus.RegWriteM_i = 1; bus.RdM_i = 7; bus.Rs1E_i = 7;
      bus.RegWriteW_i = 1; bus.RdW_i = 7; bus.Rs2E_i = 7;
      bus.ResultSrcE_i = RESULT_LOAD; bus.RdE_i = 5; bus.Rs1D_i = 5;
      bus.MemAccessM_i = 1; bus.DMemReady_i = 0;
      #1;
      chk("inv_fwd_a", bus.ForwardAE_o, FWD_REG);
      chk("inv_fwd_b", bus.ForwardBE_o, FWD_REG);
      chk("inv_stall_f", bus.StallF_o, 0);
      chk("inv_flush_e", bus.FlushE_o, 0);
      chk("inv_stall_m", bus.StallM_o, 0);
      set_idle();
      cyc(); rst = 1'b1;
      repeat (4) cyc();
      mid();
      chk("fill_valid_e", bus.ValidE_o, 1);
      chk("fill_valid_m", bus.ValidM_o, 1);
      chk("fill_valid_w", bus.ValidW_o, 1);

      // ---- forwarding priority
      cyc(); bus.RegWriteM_i = 1; bus.RegWriteW_i = 1; bus.RdM_i = 7; bus.RdW_i = 7;
      bus.Rs1E_i = 7; bus.Rs2E_i = 3;
      mid();
      chk("fwd_a_mem", bus.ForwardAE_o, FWD_MEM);
      chk("fwd_b_none", bus.ForwardBE_o, FWD_REG);
      cyc(); bus.RdM_i = 0; bus.Rs2E_i = 7;
      mid();
      chk("fwd_a_wb", bus.ForwardAE_o, FWD_WB);
      chk("fwd_b_wb", bus.ForwardBE_o, FWD_WB);
      cyc(); bus.RegWriteW_i = 0; bus.RdM_i = 3; bus.Rs2E_i = 3;
      mid();
      chk("fwd_a_nowrite", bus.ForwardAE_o, FWD_REG);
      chk("fwd_b_mem", bus.ForwardBE_o, FWD_MEM);
      cyc(); set_idle(); bus.RegWriteM_i = 1; bus.RegWriteW_i = 1;
      mid();
      chk("fwd_a_x0", bus.ForwardAE_o, FWD_REG);

      // ---- load-use
      cyc(); set_idle(); bus.ResultSrcE_i = RESULT_LOAD; bus.RdE_i = 5; bus.Rs1D_i = 5;
      mid();
      chk("lu_stall_f", bus.StallF_o, 1);
      chk("lu_stall_d", bus.StallD_o, 1);
      chk("lu_flush_e", bus.FlushE_o, 1);
      chk("lu_flush_d", bus.FlushD_o, 0);
      chk("lu_stall_e", bus.StallE_o, 0);
      chk("lu_cnt_before", bus.StallCnt_o, 0);
      cyc();
      mid();
      chk("lu_one_cycle", bus.StallF_o, 0);
      chk("lu_valid_e", bus.ValidE_o, 0);
      chk("lu_stall_cnt", bus.StallCnt_o, 1);
      cyc(); set_idle(); bus.Rs1E_i = 5; bus.RegWriteW_i = 1; bus.RdW_i = 5;
      mid();
      chk("lu_fwd_wb", bus.ForwardAE_o, FWD_WB);
      chk("lu_valid_m", bus.ValidM_o, 0);
      cyc();
      mid();
      chk("bubble_no_fwd", bus.ForwardAE_o, FWD_REG);
      chk("bubble_valid_w", bus.ValidW_o, 0);

      // ---- taken branch masks load-use
      cyc(); set_idle(); bus.PCSrcE_i = 1; bus.ResultSrcE_i = RESULT_LOAD; bus.RdE_i = 6; bus.Rs2D_i = 6;
      mid();
      chk("br_flush_d", bus.FlushD_o, 1);
      chk("br_flush_e", bus.FlushE_o, 1);
      chk("br_stall_f", bus.StallF_o, 0);
      chk("br_flush_cnt_before", bus.FlushCnt_o, 0);
      cyc(); set_idle();
      mid();
      chk("br_flush_cnt", bus.FlushCnt_o, 1);
      chk("br_stall_cnt", bus.StallCnt_o, 1);
      chk("br_valid_e", bus.ValidE_o, 0);
      repeat (4) cyc();
      mid();
      chk("refill_valid_m", bus.ValidM_o, 1);
      chk("refill_valid_w", bus.ValidW_o, 1);

      // ---- memory wait, 3 cycles then ready
      cyc(); bus.MemAccessM_i = 1; bus.DMemReady_i = 0; bus.PCSrcE_i = 1;
      mid();
      chk("mw_stall_f", bus.StallF_o, 1);
      chk("mw_stall_d", bus.StallD_o, 1);
      chk("mw_stall_e", bus.StallE_o, 1);
      chk("mw_stall_m", bus.StallM_o, 1);
      chk("mw_bubble_w", bus.BubbleW_o, 1);
      chk("mw_flush_d", bus.FlushD_o, 0);
      chk("mw_flush_e", bus.FlushE_o, 0);
      cyc(); bus.PCSrcE_i = 0;
      mid();
      chk("mw2_stall_m", bus.StallM_o, 1);
      chk("mw2_valid_w", bus.ValidW_o, 0);
      cyc();
      mid();
      chk("mw3_stall_m", bus.StallM_o, 1);
      chk("mw3_valid_w", bus.ValidW_o, 0);
      cyc(); bus.DMemReady_i = 1;
      mid();
      chk("mw_rel_stall_m", bus.StallM_o, 0);
      chk("mw_rel_stall_f", bus.StallF_o, 0);
      chk("mw_rel_bubble_w", bus.BubbleW_o, 0);
      chk("mw_rel_valid_w", bus.ValidW_o, 0);
      chk("mw_stall_cnt", bus.StallCnt_o, 4);
      chk("mw_flush_cnt", bus.FlushCnt_o, 1);
      chk("mw_no_timeout", bus.MemTimeout_o, 0);
      cyc(); set_idle();
      mid();
      chk("mw_valid_w_back", bus.ValidW_o, 1);

      // ---- timeout after 4 stalled cycles
      for (int i = 0; i < 4; i++) begin
         cyc(); bus.MemAccessM_i = 1; bus.DMemReady_i = 0;
         mid();
         chk("to_stall_m", bus.StallM_o, 1);
         chk("to_flag_clear", bus.MemTimeout_o, 0);
      end
      cyc();
      mid();
      chk("to_release_m", bus.StallM_o, 0);
      chk("to_release_f", bus.StallF_o, 0);
      chk("to_flag", bus.MemTimeout_o, 1);
      chk("to_stall_cnt", bus.StallCnt_o, 8);
      cyc();
      mid();
      chk("to_sticky", bus.MemTimeout_o, 1);
      chk("to_sticky_stall", bus.StallM_o, 0);

      // ---- reset pulse clears flag and counters
      cyc(); set_idle(); rst = 1'b0;
      #1;
      chk("rp_timeout", bus.MemTimeout_o, 0);
      chk("rp_stall_cnt", bus.StallCnt_o, 0);
      chk("rp_flush_cnt", bus.FlushCnt_o, 0);
      chk("rp_valid_m", bus.ValidM_o, 0);
      cyc(); rst = 1'b1;
      repeat (4) cyc();
      // ---- reset asserted in the middle of a wait
      bus.MemAccessM_i = 1; bus.DMemReady_i = 0;
      mid();
      chk("rw_stall", bus.StallM_o, 1);
      cyc();
      mid();
      chk("rw_stall2", bus.StallM_o, 1);
      rst = 1'b0;
      #1;
      chk("rw_stall_f", bus.StallF_o, 0);
      chk("rw_bubble_w", bus.BubbleW_o, 0);
      chk("rw_valid_w", bus.ValidW_o, 0);
      chk("rw_stall_cnt", bus.StallCnt_o, 0);
      chk("rw_timeout", bus.MemTimeout_o, 0);
      cyc(); set_idle(); rst = 1'b1;
      repeat (4) cyc();

      // ---- 21 stalled cycles saturate the 4-bit counter, then clear
      for (int b = 0; b < 7; b++) begin
         for (int k = 0; k < 3; k++) begin
            cyc(); bus.MemAccessM_i = 1; bus.DMemReady_i = 0;
            mid();
            chk("sat_burst_stall", bus.StallF_o, 1);
         end
         cyc(); bus.DMemReady_i = 1;
         mid();
         chk("sat_no_timeout", bus.MemTimeout_o, 0);
      end
      chk("sat_value", bus.StallCnt_o, 4'hF);
      cyc(); bus.MemAccessM_i = 1; bus.DMemReady_i = 0; bus.ClrCnt_i = 1;
      mid();
      chk("clr_stall_active", bus.StallF_o, 1);
      cyc(); set_idle();
      mid();
      chk("clr_stall_cnt", bus.StallCnt_o, 0);
      chk("clr_flush_cnt", bus.FlushCnt_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be: REGISTER_ADDRESS_WIDTH, default 5, register index width; COUNTER_WIDTH, default 32, performance counter width; MEM_TIMEOUT, default 255, maximum data-memory wait cycles before timeout.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset. Ports are listed as name, direction, width, meaning:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-low reset.
REQ-003 Operand and destination inputs:
- Rs1D_i and Rs2D_i, in, REGISTER_ADDRESS_WIDTH, source registers in Decode.
- Rs1E_i and Rs2E_i, in, REGISTER_ADDRESS_WIDTH, source registers in Execute.
- RdE_i, RdM_i and RdW_i, in, REGISTER_ADDRESS_WIDTH, destination registers in Execute, Memory and Writeback.
REQ-004 Control inputs:
- ResultSrcE_i, in, 2, result select in Execute; 2'b01 means load.
- RegWriteM_i and RegWriteW_i, in, 1 each, register write enables in Memory and Writeback.
- PCSrcE_i, in, 1, branch or jump taken in Execute.
- MemAccessM_i, in, 1, load or store in Memory.
- DMemReady_i, in, 1, data memory completes this cycle.
- ClrCnt_i, in, 1, synchronous counter clear.
REQ-005 Forwarding and stall outputs:
- ForwardAE_o and ForwardBE_o, out, 2 each, operand select: 00 register file, 10 Memory-stage ALU result, 01 Writeback result.
- StallF_o, StallD_o, StallE_o and StallM_o, out, 1 each, hold the stage register.
REQ-006 Flush and status outputs:
- FlushD_o and FlushE_o, out, 1 each, clear the stage register.
- BubbleW_o, out, 1, insert a no-op into Writeback.
- ValidE_o, ValidM_o and ValidW_o, out, 1 each, stage-valid bits.
- MemTimeout_o, out, 1, sticky memory-timeout flag.
- StallCnt_o and FlushCnt_o, out, COUNTER_WIDTH each, performance counters.

Function
REQ-007 Forwarding SHALL be combinational:
- ForwardAE_o SHALL be 10 when RegWriteM_i, ValidM_o, RdM_i != 0 and RdM_i == Rs1E_i all hold.
- Otherwise ForwardAE_o SHALL be 01 when RegWriteW_i, ValidW_o, RdW_i != 0 and RdW_i == Rs1E_i all hold.
- Otherwise ForwardAE_o SHALL be 00.
- ForwardBE_o SHALL follow the same rules using Rs2E_i.
- Code 11 SHALL never be driven.
REQ-008 Load-use condition lwStall SHALL be true when ResultSrcE_i == 01, ValidE_o, RdE_i != 0, and RdE_i equals Rs1D_i or Rs2D_i.
REQ-009 Memory-wait condition memStall SHALL be true when ValidM_o, MemAccessM_i and !DMemReady_i all hold, and MemTimeout_o is clear.
REQ-010 When memStall is true, the block SHALL drive:
- StallF_o, StallD_o, StallE_o, StallM_o and BubbleW_o high.
- FlushD_o and FlushE_o low.
- PCSrcE_i and lwStall ignored until memStall deasserts.
REQ-011 When memStall is false, the block SHALL drive:
- FlushD_o = PCSrcE_i.
- FlushE_o = PCSrcE_i | lwStall.
- StallF_o = StallD_o = lwStall & !PCSrcE_i.
- StallE_o = StallM_o = BubbleW_o = 0.
- A taken branch SHALL therefore mask the load-use stall.
REQ-012 Valid bits SHALL update on the clock edge:
- ValidD, internal, SHALL become 0 if FlushD_o, hold if StallD_o, and become 1 otherwise.
- ValidE_o SHALL become 0 if FlushE_o, hold if StallE_o, and take ValidD otherwise.
- ValidM_o SHALL hold if StallM_o and take ValidE_o otherwise.
- ValidW_o SHALL become 0 if BubbleW_o and take ValidM_o otherwise.
REQ-013 Memory FSM states SHALL be IDLE and WAIT:
- IDLE SHALL go to WAIT when memStall is true.
- WAIT SHALL go to IDLE when DMemReady_i is true or ValidM_o is false.
- A 9-bit-minimum wait counter SHALL count cycles spent in WAIT and clear on entry to IDLE.
REQ-014 When the wait counter reaches MEM_TIMEOUT:
- MemTimeout_o SHALL set and remain set until reset.
- The FSM SHALL return to IDLE.
- memStall SHALL be forced false, so the pipeline proceeds.
REQ-015 Counters SHALL behave as follows:
- StallCnt_o SHALL increment on each cycle StallF_o is high.
- FlushCnt_o SHALL increment on each cycle FlushD_o is high.
- Both SHALL saturate at all-ones and never wrap.
- ClrCnt_i SHALL zero both next cycle, taking priority over increment.
REQ-016 The outputs in REQ-007, REQ-010 and REQ-011 SHALL be valid in the same cycle as their inputs, with zero latency.

Reset
REQ-017 On rst_i low, the following SHALL clear asynchronously:
- ValidD, ValidE_o, ValidM_o and ValidW_o SHALL clear to 0.
- The FSM SHALL return to IDLE, and the wait counter SHALL clear to 0.
- MemTimeout_o SHALL clear to 0.
- StallCnt_o and FlushCnt_o SHALL clear to 0.
REQ-018 Reset asserted mid-WAIT SHALL abandon the wait, with no timeout recorded.
REQ-019 While all valid bits are 0, no forwarding, load-use stall or memory stall SHALL occur.

Structure
REQ-020 Package hazard_pkg SHALL hold:
- Forwarding codes FWD_REG=00, FWD_WB=01 and FWD_MEM=10.
- RESULT_LOAD=01.
- The memory FSM state enum {IDLE, WAIT}.
REQ-021 Sub-module sat_counter (parameter WIDTH; inputs inc and clr; output count) SHALL be instantiated twice, once per performance counter.

Verification
REQ-022 Load-use: load to x5 in Execute with Rs1D_i=5 -> StallF_o=StallD_o=FlushE_o=1 for 1 cycle; next cycle ForwardAE_o=01; StallCnt_o=1.
REQ-023 Forward priority: RdM_i=RdW_i=Rs1E_i=7, both writes on -> ForwardAE_o=10; RdM_i=0 -> ForwardAE_o=01.
REQ-024 Branch with simultaneous load-use: PCSrcE_i=1 with lwStall true -> FlushD_o=FlushE_o=1, StallF_o=0; FlushCnt_o=1.
REQ-025 Memory wait: MemAccessM_i=1 and DMemReady_i=0 for 3 cycles, then 1 -> all four stalls and BubbleW_o high for exactly 3 cycles; ValidW_o=0 during them.
REQ-026 Timeout: MEM_TIMEOUT=4 with DMemReady_i held 0 -> stalls for 4 cycles, then MemTimeout_o=1 sticky and stalls released.
REQ-027 Reset and counters: assert rst_i low during WAIT -> all outputs reset immediately; then force 2^COUNTER_WIDTH+3 stall cycles -> StallCnt_o stays at all-ones; ClrCnt_i -> 0.
